// File: rtl/sparc_mem_pkg.sv
// Shared SPARC memory-port definitions: loader state encoding, r/w and access-size codes.
// Also consumed by the control unit, so keep encodings stable.
package sparc_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_L_WAIT = 3'd1,
    ST_L_MOV  = 3'd2,
    ST_L_REL  = 3'd3,
    ST_D_MOV  = 3'd4,
    ST_D_REL  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } loader_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [1:0] TYPE_BYTE  = 2'b00;
  localparam logic [1:0] TYPE_HALF  = 2'b01;
  localparam logic [1:0] TYPE_WORD  = 2'b10;
  localparam logic [1:0] TYPE_DWORD = 2'b11;

  function automatic logic [31:0] byte_to_word(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/sparc_moc_handshake.sv
// MFA/MOC handshake helper: drives mov from the request and watches MOC with a
// down-counting timeout that reloads whenever the request is idle.
module sparc_moc_handshake #(
  parameter int MOC_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_moc,
  output logic o_mov,
  output logic o_done,
  output logic o_released,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LP_TC_LOAD = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Reload while idle so every new request gets the full window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_cnt <= LP_TC_LOAD;
    else if (!i_req)         r_cnt <= LP_TC_LOAD;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_mov      = i_req;
  assign o_done     = i_req & i_moc;
  assign o_released = ~i_moc;
  assign o_timeout  = i_req & ~i_moc & (r_cnt == '0);

endmodule

// File: rtl/sparc_ram_loader.sv
// Owns the SPARC_RAM port while the MPU is held: streams a byte image into RAM
// (load), reads it back byte-by-byte (dump), and releases cpu_hold after a load.
//
// state   | meaning
// IDLE    | port idle, waiting for start_load / start_dump
// L_WAIT  | in_ready high, waiting for an image byte
// L_MOV   | write request (mov=1, rw=0) until MOC
// L_REL   | mov dropped, waiting for MOC low, then advance
// D_MOV   | read request (mov=1, rw=1) until MOC, capture byte
// D_REL   | mov dropped, waiting for MOC low, then advance
// DONE    | finished; accepts new starts like IDLE
// ERR     | MOC timeout or address overflow; accepts new starts
module sparc_ram_loader
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DUMP_LAST   = 60,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [7:0]        dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  output logic              ram_mov,
  output logic              ram_rw,
  output logic [1:0]        ram_type,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic              ram_moc,
  output logic              cpu_hold,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [ADDR_W-1:0] LP_DUMP_LAST = ADDR_W'(DUMP_LAST);

  loader_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_byte_count;
  logic [7:0]        r_din;
  logic              r_last;
  logic              r_cpu_hold;
  logic              r_error;
  logic [7:0]        r_dump_data;
  logic [ADDR_W-1:0] r_dump_addr;
  logic              r_dump_valid;

  logic w_req, w_mov, w_done, w_released, w_timeout;
  logic w_idle_like, w_start_load, w_start_dump;
  logic w_in_ready, w_rw, w_busy;
  logic w_unused_dout;

  assign w_unused_dout = ^ram_dout[31:8];

  sparc_moc_handshake #(.MOC_TIMEOUT(MOC_TIMEOUT)) u_hs (
    .i_clk      (Clk),
    .i_rst      (Clr),
    .i_req      (w_req),
    .i_moc      (ram_moc),
    .o_mov      (w_mov),
    .o_done     (w_done),
    .o_released (w_released),
    .o_timeout  (w_timeout)
  );

  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_start_load = w_idle_like & start_load;
  assign w_start_dump = w_idle_like & ~start_load & start_dump;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_in_ready  = 1'b0;
    w_rw        = RW_READ;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        w_busy = 1'b0;
        if (w_start_load)      w_state_nxt = ST_L_WAIT;
        else if (w_start_dump) w_state_nxt = ST_D_MOV;
      end
      ST_L_WAIT: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_L_MOV;
      end
      ST_L_MOV: begin
        w_req = 1'b1;
        w_rw  = RW_WRITE;
        if (w_done)         w_state_nxt = ST_L_REL;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_L_REL: begin
        w_rw = RW_WRITE;
        if (w_released) begin
          if (r_last)       w_state_nxt = ST_DONE;
          else if (&r_addr) w_state_nxt = ST_ERR;
          else              w_state_nxt = ST_L_WAIT;
        end
      end
      ST_D_MOV: begin
        w_req = 1'b1;
        if (w_done)         w_state_nxt = ST_D_REL;
        else if (w_timeout) w_state_nxt = ST_ERR;
      end
      ST_D_REL: begin
        if (w_released) w_state_nxt = (r_addr == LP_DUMP_LAST) ? ST_DONE : ST_D_MOV;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_addr       <= '0;
      r_byte_count <= '0;
      r_din        <= '0;
      r_last       <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_error      <= 1'b0;
      r_dump_data  <= '0;
      r_dump_addr  <= '0;
      r_dump_valid <= 1'b0;
    end else begin
      r_dump_valid <= 1'b0;
      if (w_start_load) begin
        r_addr       <= '0;
        r_byte_count <= '0;
        r_cpu_hold   <= 1'b1;
        r_error      <= 1'b0;
      end
      if (w_start_dump) begin
        r_addr  <= '0;
        r_error <= 1'b0;
      end
      if (r_state == ST_L_WAIT && in_valid) begin
        r_din  <= in_data;
        r_last <= in_last;
      end
      if (r_state == ST_L_REL && w_released) begin
        r_byte_count <= r_byte_count + 1'b1;
        if (r_last)        r_cpu_hold <= 1'b0;
        else if (!(&r_addr)) r_addr   <= r_addr + 1'b1;
      end
      if (r_state == ST_D_MOV && w_done) begin
        r_dump_data  <= ram_dout[7:0];
        r_dump_addr  <= r_addr;
        r_dump_valid <= 1'b1;
      end
      if (r_state == ST_D_REL && w_released && r_addr != LP_DUMP_LAST)
        r_addr <= r_addr + 1'b1;
      if (w_state_nxt == ST_ERR && r_state != ST_ERR)
        r_error <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign ram_mov    = w_mov;
  assign ram_rw     = w_rw;
  assign ram_type   = TYPE_BYTE;
  assign ram_addr   = r_addr;
  assign ram_din    = byte_to_word(r_din);
  assign dump_data  = r_dump_data;
  assign dump_addr  = r_dump_addr;
  assign dump_valid = r_dump_valid;
  assign cpu_hold   = r_cpu_hold;
  assign error      = r_error;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// Directed bench for sparc_ram_loader with a behavioural byte RAM that returns
// MOC after a programmable delay (or never).
module tb_sparc_ram_loader;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        start_load = 1'b0, start_dump = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  dump_data;
  logic [8:0]  dump_addr;
  logic        dump_valid;
  logic        ram_mov, ram_rw;
  logic [1:0]  ram_type;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;
  logic        ram_moc = 1'b0;
  logic        cpu_hold, busy, error;
  logic [9:0]  byte_count;

  sparc_ram_loader #(.ADDR_W(9), .DUMP_LAST(3), .MOC_TIMEOUT(15)) dut (
    .Clk(Clk), .Clr(Clr), .start_load(start_load), .start_dump(start_dump),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_moc(ram_moc),
    .cpu_hold(cpu_hold), .busy(busy), .error(error), .byte_count(byte_count)
  );

  always #5 Clk = ~Clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   stim_timeouts = 0;
  int   moc_delay = 1;
  bit   no_moc = 1'b0;
  bit   clr_mem = 1'b0;
  logic [7:0] mem [512];
  int   wcount [512];
  int   moc_cnt = 0;
  int   ready_viol = 0;
  logic [8:0] dq_addr [$];
  logic [7:0] dq_data [$];

  // RAM model: MOC rises moc_delay cycles after mov, falls once mov drops.
  always @(posedge Clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 512; i++) begin
        mem[i]    <= 8'h00;
        wcount[i] <= 0;
      end
    end
    if (!ram_mov) begin
      ram_moc <= 1'b0;
      moc_cnt <= 0;
    end else if (!ram_moc && !no_moc) begin
      if (moc_cnt + 1 >= moc_delay) begin
        ram_moc <= 1'b1;
        if (ram_rw == 1'b0) begin
          mem[ram_addr]    <= ram_din[7:0];
          wcount[ram_addr] <= wcount[ram_addr] + 1;
        end else begin
          ram_dout <= {24'h0, mem[ram_addr]};
        end
      end else begin
        moc_cnt <= moc_cnt + 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (dump_valid) begin
      dq_addr.push_back(dump_addr);
      dq_data.push_back(dump_data);
    end
    if (in_ready && (ram_mov || !busy)) ready_viol++;
  end

  task automatic pulse_load();
    @(negedge Clk); start_load = 1'b1;
    @(negedge Clk); start_load = 1'b0;
  endtask

  task automatic pulse_dump();
    @(negedge Clk); start_dump = 1'b1;
    @(negedge Clk); start_dump = 1'b0;
  endtask

  task automatic do_clr_mem();
    @(negedge Clk); clr_mem = 1'b1;
    @(negedge Clk); clr_mem = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge Clk);
    in_data = d; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge Clk); n++; end
    if (!in_ready) stim_timeouts++;
    @(negedge Clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy && n < 500) begin @(negedge Clk); n++; end
    if (busy) stim_timeouts++;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset cpu_hold: got %b expected 1", cpu_hold); end
    n_checks++; if (ram_rw !== 1'b1) begin n_fail++; $display("FAIL reset ram_rw: got %b expected 1", ram_rw); end
    n_checks++; if ({ram_mov, busy, error, in_ready, dump_valid} !== 5'b0) begin n_fail++; $display("FAIL reset flags mov/busy/err/rdy/dv: got %b expected 00000", {ram_mov, busy, error, in_ready, dump_valid}); end
    n_checks++; if ({ram_addr, byte_count, ram_type} !== 21'h0 || ram_din !== 32'h0) begin n_fail++; $display("FAIL reset addr/count/type/din: got %0h %0h %0h %0h expected 0", ram_addr, byte_count, ram_type, ram_din); end
    Clr = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_load_basic();
    logic [7:0] img [4];
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    moc_delay = 1;
    do_clr_mem();
    pulse_load();
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL load_basic enter L_WAIT rdy/busy: got %b%b expected 11", in_ready, busy); end
    for (int i = 0; i < 4; i++) send_byte(img[i], i == 3, 0);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_basic cpu_hold before done: got %b expected 1", cpu_hold); end
    wait_not_busy();
    n_checks++; if (stim_timeouts !== 0) begin n_fail++; $display("FAIL load_basic handshake bound: got %0d expired expected 0", stim_timeouts); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[i] !== img[i] || wcount[i] !== 1) begin n_fail++; $display("FAIL load_basic mem[%0d]: got %0h x%0d expected %0h x1", i, mem[i], wcount[i], img[i]); end
    end
    n_checks++; if (byte_count !== 10'd4) begin n_fail++; $display("FAIL load_basic byte_count: got %0d expected 4", byte_count); end
    n_checks++; if (cpu_hold !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL load_basic hold/err: got %b%b expected 00", cpu_hold, error); end
  endtask

  task automatic test_load_gaps();
    logic [7:0] img [4];
    int gaps [4];
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    gaps[0] = 0; gaps[1] = 3; gaps[2] = 7; gaps[3] = 0;
    moc_delay = 5;
    do_clr_mem();
    pulse_load();
    for (int i = 0; i < 4; i++) send_byte(img[i], i == 3, gaps[i]);
    wait_not_busy();
    n_checks++; if (stim_timeouts !== 0) begin n_fail++; $display("FAIL load_gaps handshake bound: got %0d expired expected 0", stim_timeouts); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (mem[i] !== img[i] || wcount[i] !== 1) begin n_fail++; $display("FAIL load_gaps mem[%0d]: got %0h x%0d expected %0h x1", i, mem[i], wcount[i], img[i]); end
    end
    n_checks++; if (wcount[4] !== 0) begin n_fail++; $display("FAIL load_gaps stray write addr4: got %0d expected 0", wcount[4]); end
    n_checks++; if (byte_count !== 10'd4 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load_gaps count/hold: got %0d/%b expected 4/0", byte_count, cpu_hold); end
    n_checks++; if (ready_viol !== 0) begin n_fail++; $display("FAIL load_gaps in_ready outside L_WAIT: got %0d cycles expected 0", ready_viol); end
  endtask

  task automatic test_dump();
    int base;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    moc_delay = 2;
    base = dq_addr.size();
    pulse_dump();
    n_checks++; if (ram_mov !== 1'b1 || ram_rw !== 1'b1) begin n_fail++; $display("FAIL dump read request mov/rw: got %b%b expected 11", ram_mov, ram_rw); end
    wait_not_busy();
    repeat (2) @(negedge Clk);
    n_checks++; if (dq_addr.size() - base !== 4) begin n_fail++; $display("FAIL dump pulse count: got %0d expected 4", dq_addr.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < dq_addr.size()) begin
        n_checks++; if (dq_addr[base+i] !== 9'(i) || dq_data[base+i] !== exp_d[i]) begin n_fail++; $display("FAIL dump pair %0d: got (%0d,%0h) expected (%0d,%0h)", i, dq_addr[base+i], dq_data[base+i], i, exp_d[i]); end
      end
    end
    n_checks++; if (cpu_hold !== 1'b0 || error !== 1'b0 || stim_timeouts !== 0) begin n_fail++; $display("FAIL dump hold/err/bound: got %b%b/%0d expected 00/0", cpu_hold, error, stim_timeouts); end
  endtask

  task automatic test_both_starts();
    moc_delay = 1;
    @(negedge Clk); start_load = 1'b1; start_dump = 1'b1;
    @(negedge Clk); start_load = 1'b0; start_dump = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || ram_mov !== 1'b0) begin n_fail++; $display("FAIL both_starts load priority rdy/mov: got %b%b expected 10", in_ready, ram_mov); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL both_starts cpu_hold reasserted: got %b expected 1", cpu_hold); end
    send_byte(8'h5A, 1'b1, 0);
    wait_not_busy();
    n_checks++; if (mem[0] !== 8'h5A || byte_count !== 10'd1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL both_starts result mem0/count/hold: got %0h/%0d/%b expected 5a/1/0", mem[0], byte_count, cpu_hold); end
  endtask

  task automatic test_timeout();
    int movc, n;
    no_moc = 1'b1;
    pulse_load();
    send_byte(8'h77, 1'b1, 0);
    movc = 0; n = 0;
    while (!error && n < 100) begin
      if (ram_mov) movc++;
      @(negedge Clk); n++;
    end
    no_moc = 1'b0;
    n_checks++; if (movc !== 15) begin n_fail++; $display("FAIL timeout mov cycles: got %0d expected 15", movc); end
    n_checks++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout err/hold: got %b%b expected 11", error, cpu_hold); end
    n_checks++; if (ram_mov !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout mov/busy after ERR: got %b%b expected 00", ram_mov, busy); end
    repeat (3) @(negedge Clk);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout error sticky: got %b expected 1", error); end
    pulse_dump();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL timeout error cleared by start: got %b expected 0", error); end
    wait_not_busy();
    n_checks++; if (error !== 1'b0 || cpu_hold !== 1'b1 || stim_timeouts !== 0) begin n_fail++; $display("FAIL timeout post-dump err/hold/bound: got %b%b/%0d expected 01/0", error, cpu_hold, stim_timeouts); end
  endtask

  task automatic test_clr_midload();
    moc_delay = 4;
    do_clr_mem();
    pulse_load();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h33, 1'b0, 0);
    n_checks++; if (ram_mov !== 1'b1 || ram_addr !== 9'd2) begin n_fail++; $display("FAIL clr 3rd byte in L_MOV mov/addr: got %b/%0d expected 1/2", ram_mov, ram_addr); end
    @(negedge Clk);
    Clr = 1'b1;
    #1;
    n_checks++; if (ram_mov !== 1'b0) begin n_fail++; $display("FAIL clr async mov drop: got %b expected 0", ram_mov); end
    n_checks++; if (cpu_hold !== 1'b1 || ram_rw !== 1'b1 || {busy, error, in_ready} !== 3'b0 || ram_addr !== 9'd0 || byte_count !== 10'd0) begin n_fail++; $display("FAIL clr reset values hold/rw/bei/addr/cnt: got %b%b/%b/%0d/%0d expected 11/000/0/0", cpu_hold, ram_rw, {busy, error, in_ready}, ram_addr, byte_count); end
    @(negedge Clk); Clr = 1'b0;
    moc_delay = 1;
    do_clr_mem();
    pulse_load();
    n_checks++; if (ram_addr !== 9'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clr restart addr/rdy: got %0d/%b expected 0/1", ram_addr, in_ready); end
    send_byte(8'hA0, 1'b1, 0);
    wait_not_busy();
    n_checks++; if (mem[0] !== 8'hA0 || wcount[0] !== 1 || byte_count !== 10'd1 || stim_timeouts !== 0) begin n_fail++; $display("FAIL clr restart result mem0/wc/cnt/bound: got %0h/%0d/%0d/%0d expected a0/1/1/0", mem[0], wcount[0], byte_count, stim_timeouts); end
  endtask

  task automatic test_overflow();
    int once;
    moc_delay = 1;
    do_clr_mem();
    pulse_load();
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0, 0);
    wait_not_busy();
    once = 0;
    for (int i = 0; i < 512; i++) if (wcount[i] == 1 && mem[i] == 8'(i)) once++;
    n_checks++; if (once !== 512) begin n_fail++; $display("FAIL overflow single writes: got %0d expected 512", once); end
    n_checks++; if (byte_count !== 10'd512) begin n_fail++; $display("FAIL overflow byte_count: got %0d expected 512", byte_count); end
    n_checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL overflow err/hold/busy: got %b%b%b expected 110", error, cpu_hold, busy); end
    n_checks++; if (ram_addr !== 9'h1FF || stim_timeouts !== 0) begin n_fail++; $display("FAIL overflow addr/bound: got %0h/%0d expected 1ff/0", ram_addr, stim_timeouts); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_load_gaps();
    test_dump();
    test_both_starts();
    test_timeout();
    test_clr_midload();
    test_overflow();
    n_checks++; if (ready_viol !== 0) begin n_fail++; $display("FAIL final in_ready outside L_WAIT: got %0d cycles expected 0", ready_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
